// File: rtl/dram_pkg.sv
// Shared types for the DRAM burst sequencer.
// Macro DRAM_DM_EN adds the per-byte write-mask types.
package dram_pkg;

  localparam int unsigned BL     = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BEAT_W = $clog2(BL);

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [BL-1:0]    burst_t;
  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_BURST,
    RD_WAIT,
    RD_BURST,
    DONE
  } burst_state_t;

`ifdef DRAM_DM_EN
  typedef logic [WORD_W/8-1:0] be_t;
  typedef be_t [BL-1:0]        mask_t;
`endif

endpackage

// File: rtl/dram_burst_ctrl_if.sv
// Scheduler / data-transfer side bundle of the burst sequencer.
// Macro DRAM_DM_EN adds wr_mask and dm_n.
interface dram_burst_ctrl_if;
  import dram_pkg::*;

  logic   wr_req;
  logic   rd_req;
  logic   req_ready;
  burst_t wr_burst;
  logic   edge_flag;
  word_t  memload;
  word_t  memstore;
  beat_t  COL_choice;
  logic   dq_oe;
  burst_t rd_burst;
  logic   done;
  logic   busy;

`ifdef DRAM_DM_EN
  mask_t  wr_mask;
  be_t    dm_n;

  modport master (
    output wr_req, rd_req, wr_burst, edge_flag, memload, wr_mask,
    input  req_ready, memstore, COL_choice, dq_oe, rd_burst, done, busy, dm_n
  );
  modport slave (
    input  wr_req, rd_req, wr_burst, edge_flag, memload, wr_mask,
    output req_ready, memstore, COL_choice, dq_oe, rd_burst, done, busy, dm_n
  );
`else
  modport master (
    output wr_req, rd_req, wr_burst, edge_flag, memload,
    input  req_ready, memstore, COL_choice, dq_oe, rd_burst, done, busy
  );
  modport slave (
    input  wr_req, rd_req, wr_burst, edge_flag, memload,
    output req_ready, memstore, COL_choice, dq_oe, rd_burst, done, busy
  );
`endif

endinterface

// File: rtl/dram_burst_buf.sv
// Eight-word burst buffer: parallel load, indexed write, indexed read, parallel read.
module dram_burst_buf
  import dram_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_en,
  input  burst_t load_data,
  input  logic   wr_en,
  input  beat_t  wr_idx,
  input  word_t  wr_data,
  input  beat_t  rd_idx,
  output word_t  rd_data,
  output burst_t q
);

  burst_t mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (load_en) begin
      mem_d = load_data;
    end else if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_idx];
  assign q       = mem_q;

endmodule

// File: rtl/dram_burst_ctrl.sv
// BL8 read/write burst sequencer: CAS/CWL wait, beat stepping on strobe edges.
// Macro DRAM_DM_EN adds per-beat active-low data mask dm_n from wr_mask.
module dram_burst_ctrl
  import dram_pkg::*;
#(
  parameter int unsigned WR_LAT = 4,
  parameter int unsigned RD_LAT = 6,
  parameter int unsigned LAT_W  = 4
) (
  input logic              CLK,
  input logic              nRST,
  dram_burst_ctrl_if.slave bus
);

  localparam logic [LAT_W-1:0] WR_LAT_C = LAT_W'(WR_LAT);
  localparam logic [LAT_W-1:0] RD_LAT_C = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0] CNT_ONE  = LAT_W'(1);

  burst_state_t     state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  beat_t            beat_q, beat_d;
  word_t            memstore_q, memstore_d;
  logic             dq_oe_q, dq_oe_d;
  logic             wload, rcap;
  word_t            wbuf_rd, store_word;
  burst_t           rbuf_q, wbuf_unused;
  word_t            rbuf_rd_unused;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      memstore_q <= '0;
      dq_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      memstore_q <= memstore_d;
      dq_oe_q    <= dq_oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    wload   = 1'b0;
    rcap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rd_req) begin
          cnt_d   = RD_LAT_C;
          state_d = (RD_LAT == 0) ? RD_BURST : RD_WAIT;
        end else if (bus.wr_req) begin
          wload   = 1'b1;
          cnt_d   = WR_LAT_C;
          state_d = (WR_LAT == 0) ? WR_BURST : WR_WAIT;
        end
      end
      // Hand off on the decrement that reaches zero so BURST lands at accept+1+LAT.
      WR_WAIT, RD_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_d == '0) begin
          state_d = (state_q == WR_WAIT) ? WR_BURST : RD_BURST;
        end
      end
      WR_BURST, RD_BURST: begin
        if (bus.edge_flag) begin
          rcap   = (state_q == RD_BURST);
          beat_d = beat_q + 1'b1;
          if (beat_q == beat_t'(BL - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        beat_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered beat outputs are loaded from the next beat; LAT=0 writes bypass the buffer.
  always_comb begin
    store_word = wload ? bus.wr_burst[beat_d] : wbuf_rd;
    dq_oe_d    = (state_d == WR_BURST);
    memstore_d = dq_oe_d ? store_word : '0;
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.memstore   = memstore_q;
  assign bus.dq_oe      = dq_oe_q;
  assign bus.COL_choice = beat_q;
  assign bus.rd_burst   = rbuf_q;

  dram_burst_buf wbuf (
    .clk       (CLK),
    .rst_n     (nRST),
    .load_en   (wload),
    .load_data (bus.wr_burst),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .rd_idx    (beat_d),
    .rd_data   (wbuf_rd),
    .q         (wbuf_unused)
  );

  dram_burst_buf rbuf (
    .clk       (CLK),
    .rst_n     (nRST),
    .load_en   (1'b0),
    .load_data ('0),
    .wr_en     (rcap),
    .wr_idx    (beat_q),
    .wr_data   (bus.memload),
    .rd_idx    ('0),
    .rd_data   (rbuf_rd_unused),
    .q         (rbuf_q)
  );

`ifdef DRAM_DM_EN
  mask_t mask_q, mask_d;
  be_t   dm_n_q, dm_n_d;

  always_comb begin
    mask_d = wload ? bus.wr_mask : mask_q;
    dm_n_d = (state_d == WR_BURST) ? ~mask_d[beat_d] : '1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mask_q <= '0;
      dm_n_q <= '1;
    end else begin
      mask_q <= mask_d;
      dm_n_q <= dm_n_d;
    end
  end

  assign bus.dm_n = dm_n_q;
`endif

endmodule

// File: tb/tb_dram_burst_ctrl.sv
// Directed bench for dram_burst_ctrl (WR_LAT=4, RD_LAT=6); DRAM_DM_EN enables the mask checks.
module tb_dram_burst_ctrl;
  import dram_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  dram_burst_ctrl_if bus ();

  dram_burst_ctrl #(
    .WR_LAT (4),
    .RD_LAT (6),
    .LAT_W  (4)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  typedef struct {
    logic        wr_req;
    logic        rd_req;
    logic        edge_flag;
    word_t       memload;
    logic [38:0] e_ctl;   // {req_ready, busy, done, dq_oe, COL_choice, memstore}
    burst_t      e_rd;
  } vec_t;

  localparam logic [38:0] IDLE_CTL = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0};
  localparam logic [38:0] WAIT_CTL = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0};
  localparam logic [38:0] DONE_CTL = {1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 32'd0};

  vec_t        vecs[$];
  vec_t        v;
  burst_t      rexp;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Expected control outputs c cycles after a write accept (edge_flag held high).
  function automatic logic [38:0] exp_wr(input int unsigned c, input word_t base);
    if (c == 0 || c >= 14) return IDLE_CTL;
    if (c <= 4)            return WAIT_CTL;
    if (c <= 12)           return {1'b0, 1'b1, 1'b0, 1'b1, 3'(c - 5), base + 32'(c - 5)};
    return DONE_CTL;
  endfunction

  function automatic logic [38:0] exp_rd(input int unsigned c);
    if (c == 0 || c >= 16) return IDLE_CTL;
    if (c <= 6)            return WAIT_CTL;
    if (c <= 14)           return {1'b0, 1'b1, 1'b0, 1'b0, 3'(c - 7), 32'd0};
    return DONE_CTL;
  endfunction

  task automatic chk_ctl(input string name, input logic [38:0] exp);
    logic [38:0] act;
    act = {bus.req_ready, bus.busy, bus.done, bus.dq_oe, bus.COL_choice, bus.memstore};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy=%b busy=%b done=%b oe=%b col=%0d store=%h, expected rdy=%b busy=%b done=%b oe=%b col=%0d store=%h",
               name, act[38], act[37], act[36], act[35], act[34:32], act[31:0],
               exp[38], exp[37], exp[36], exp[35], exp[34:32], exp[31:0]);
    end
  endtask

  task automatic chk_rd(input string name, input burst_t exp);
    n_cmp++;
    if (bus.rd_burst !== exp) begin
      n_err++;
      $display("FAIL %s: rd_burst got %h expected %h", name, bus.rd_burst, exp);
    end
  endtask

`ifdef DRAM_DM_EN
  task automatic chk_dm(input string name, input be_t exp);
    n_cmp++;
    if (bus.dm_n !== exp) begin
      n_err++;
      $display("FAIL %s: dm_n got %b expected %b", name, bus.dm_n, exp);
    end
  endtask
`endif

  initial begin
    nrst          = 1'b0;
    bus.wr_req    = 1'b0;
    bus.rd_req    = 1'b0;
    bus.edge_flag = 1'b0;
    bus.memload   = '0;
    bus.wr_burst  = '0;
`ifdef DRAM_DM_EN
    bus.wr_mask   = '0;
`endif

    // Reset state.
    @(negedge clk);
    #1;
    chk_ctl("reset_ctl", IDLE_CTL);
    chk_rd("reset_rd", '0);
`ifdef DRAM_DM_EN
    chk_dm("reset_dm", 4'hF);
`endif
    nrst = 1'b1;

    // Table: write burst then read burst, edge_flag held high throughout.
    for (int unsigned k = 0; k < BL; k++) bus.wr_burst[k] = 32'hA0 + k;
    rexp = '0;
    for (int unsigned c = 0; c < 33; c++) begin
      v.wr_req    = (c == 0);
      v.rd_req    = (c == 14);
      v.edge_flag = 1'b1;
      v.memload   = (c >= 21 && c <= 28) ? 32'h100 + (c - 21) : 32'hBAD0_0000 + c;
      v.e_ctl     = (c < 14) ? exp_wr(c, 32'hA0) : exp_rd(c - 14);
      v.e_rd      = rexp;
      vecs.push_back(v);
      if (c >= 21 && c <= 28) rexp[c - 21] = v.memload;
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.wr_req    = vecs[i].wr_req;
      bus.rd_req    = vecs[i].rd_req;
      bus.edge_flag = vecs[i].edge_flag;
      bus.memload   = vecs[i].memload;
      #1;
      chk_ctl($sformatf("tbl%0d_ctl", i), vecs[i].e_ctl);
      chk_rd($sformatf("tbl%0d_rd", i), vecs[i].e_rd);
    end

    // Simultaneous requests: read first, held write taken on return to IDLE.
    @(negedge clk);
    for (int unsigned k = 0; k < BL; k++) bus.wr_burst[k] = 32'hB0 + k;
    bus.wr_req    = 1'b1;
    bus.rd_req    = 1'b1;
    bus.edge_flag = 1'b1;
    bus.memload   = 32'h200;
    #1;
    chk_ctl("both_accept", IDLE_CTL);
    for (int unsigned k = 0; k < BL; k++) rexp[k] = 32'h207 + k;
    for (int unsigned c = 1; c <= 30; c++) begin
      @(negedge clk);
      bus.rd_req  = 1'b0;
      bus.wr_req  = (c <= 16);
      bus.memload = 32'h200 + c;
      #1;
      if (c <= 16) chk_ctl($sformatf("both_rd_c%0d", c), exp_rd(c));
      else         chk_ctl($sformatf("both_wr_c%0d", c), exp_wr(c - 16, 32'hB0));
      if (c == 15 || c == 29) chk_rd($sformatf("both_rd_c%0d", c), rexp);
    end

    // Read with edge_flag toggling 0,1 across the burst: 16 burst cycles.
    @(negedge clk);
    bus.wr_req    = 1'b0;
    bus.rd_req    = 1'b1;
    bus.edge_flag = 1'b0;
    bus.memload   = '0;
    #1;
    chk_ctl("tog_accept", IDLE_CTL);
    for (int unsigned k = 0; k < BL; k++) rexp[k] = 32'h300 + k;
    for (int unsigned c = 1; c <= 24; c++) begin
      int unsigned j;
      logic [38:0] e;
      @(negedge clk);
      bus.rd_req = 1'b0;
      j = c - 7;
      if (c >= 7 && c <= 22) begin
        bus.edge_flag = (j % 2 == 1);
        bus.memload   = bus.edge_flag ? 32'h300 + j / 2 : 32'hDEAD_0000 + c;
      end else begin
        bus.edge_flag = 1'b1;
        bus.memload   = 32'hDEAD_0000 + c;
      end
      #1;
      if (c <= 6)       e = WAIT_CTL;
      else if (c <= 22) e = {1'b0, 1'b1, 1'b0, 1'b0, 3'(j / 2), 32'd0};
      else if (c == 23) e = DONE_CTL;
      else              e = IDLE_CTL;
      chk_ctl($sformatf("tog_c%0d", c), e);
      if (c >= 23) chk_rd($sformatf("tog_rd_c%0d", c), rexp);
    end

    // Reset asserted during beat 3 of a write.
    @(negedge clk);
    for (int unsigned k = 0; k < BL; k++) bus.wr_burst[k] = 32'hD0 + k;
    bus.wr_req    = 1'b1;
    bus.edge_flag = 1'b1;
    for (int unsigned c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.wr_req = 1'b0;
    end
    #1;
    chk_ctl("abort_beat3", exp_wr(8, 32'hD0));
    #1;
    nrst = 1'b0;
    #1;
    chk_ctl("abort_rst_ctl", IDLE_CTL);
    chk_rd("abort_rst_rd", '0);
`ifdef DRAM_DM_EN
    chk_dm("abort_rst_dm", 4'hF);
`endif
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk_ctl($sformatf("abort_hold%0d", c), IDLE_CTL);
    end
    nrst = 1'b1;

    // Next write after the abort completes normally; mask only beat 2.
    @(negedge clk);
    for (int unsigned k = 0; k < BL; k++) bus.wr_burst[k] = 32'hE0 + k;
`ifdef DRAM_DM_EN
    bus.wr_mask    = '0;
    bus.wr_mask[2] = 4'b0101;
`endif
    bus.wr_req = 1'b1;
    #1;
    chk_ctl("post_c0", exp_wr(0, 32'hE0));
    for (int unsigned c = 1; c <= 14; c++) begin
      @(negedge clk);
      bus.wr_req = 1'b0;
      #1;
      chk_ctl($sformatf("post_c%0d", c), exp_wr(c, 32'hE0));
`ifdef DRAM_DM_EN
      chk_dm($sformatf("post_dm_c%0d", c), (c == 7) ? 4'b1010 : 4'hF);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
